// File: rtl/fp32_pkg.sv
// Shared binary32 field layout, constants and divider state encoding.
// FP_DIV_ROUND_NEAREST_EN selects round-to-nearest-even (two extra quotient bits) instead of truncation.
package fp32_pkg;

  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned EXP_BITS  = 8;
  localparam int unsigned FRAC_BITS = 23;
  localparam int unsigned MANT_BITS = FRAC_BITS + 1;
  localparam int unsigned SIGN_POS  = 31;
  localparam int unsigned EXP_LSB   = 23;
  localparam int unsigned BIAS      = 127;
  localparam int unsigned CNT_W     = 5;

`ifdef FP_DIV_ROUND_NEAREST_EN
  localparam int unsigned QBITS = MANT_BITS + 3;
`else
  localparam int unsigned QBITS = MANT_BITS + 1;
`endif

  localparam logic [WORD_BITS-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [WORD_BITS-1:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_DIVIDE,
    ST_NORM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fp32_divider_if.sv
// Operand / result handshake bundle of the divide unit.
interface fp32_divider_if;
  logic [31:0] A;
  logic [31:0] B;
  logic        En;
  logic [31:0] Result;
  logic        Ready;
  logic        NaN;

  modport master (output A, output B, output En, input Result, input Ready, input NaN);
  modport slave  (input A, input B, input En, output Result, output Ready, output NaN);
endinterface

// File: rtl/fp32_classify.sv
// Combinational operand decode; subnormals are flushed to zero.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [WORD_BITS-1:0] x,
  output logic                 sign,
  output logic [EXP_BITS-1:0]  exp,
  output logic [MANT_BITS-1:0] mant,
  output logic                 is_zero,
  output logic                 is_inf,
  output logic                 is_nan
);

  logic [FRAC_BITS-1:0] frac;
  logic                 exp_max;

  assign sign    = x[SIGN_POS];
  assign exp     = x[EXP_LSB +: EXP_BITS];
  assign frac    = x[FRAC_BITS-1:0];
  assign exp_max = &exp;
  assign is_zero = (exp == '0);
  assign is_inf  = exp_max & ~(|frac);
  assign is_nan  = exp_max & (|frac);
  assign mant    = {~is_zero, frac};

endmodule

// File: rtl/fp32_divider.sv
// Sequential binary32 divider: restoring division, one quotient bit per cycle.
// FP_DIV_ROUND_NEAREST_EN enables round-to-nearest-even; default build truncates.
module fp32_divider
  import fp32_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 23
) (
  input  logic           clk,
  input  logic           reset,
  fp32_divider_if.slave  bus
);

  localparam int unsigned WORD_W = 1 + EXP_W + MANT_W;
  localparam int unsigned MFULL  = MANT_W + 1;
  localparam int unsigned REM_W  = MANT_W + 3;
  localparam int unsigned SEXP_W = EXP_W + 2;

  state_t                    state;
  logic [WORD_W-1:0]         a_q, b_q, res_q;
  logic                      nan_q, sign_q;
  logic [REM_W-1:0]          rem_q;
  logic [MFULL-1:0]          mb_q;
  logic [QBITS-1:0]          q_q;
  logic signed [SEXP_W-1:0]  exp_q;
  logic [CNT_W-1:0]          cnt_q;

  logic                 sa, sb, za, zb, ia, ib, na, nb;
  logic [EXP_BITS-1:0]  ea, eb;
  logic [MANT_BITS-1:0] ma, mb;

  fp32_classify u_cls_a (.x(a_q), .sign(sa), .exp(ea), .mant(ma),
                         .is_zero(za), .is_inf(ia), .is_nan(na));
  fp32_classify u_cls_b (.x(b_q), .sign(sb), .exp(eb), .mant(mb),
                         .is_zero(zb), .is_inf(ib), .is_nan(nb));

  // Restoring division step: trial subtract of the divisor from the partial remainder.
  logic [REM_W-1:0] diff_c;
  logic             ge_c;
  assign ge_c   = (rem_q >= REM_W'(mb_q));
  assign diff_c = rem_q - REM_W'(mb_q);

  // Normalisation, optional rounding and range clamping of the finished quotient.
  logic                     msb_c;
  logic [FRAC_BITS-1:0]     frac_t_c, frac_c;
  logic signed [SEXP_W-1:0] exp_t_c, exp_c;
  logic [WORD_W-1:0]        norm_res_c;
`ifdef FP_DIV_ROUND_NEAREST_EN
  logic                     guard_c, rnd_c, sticky_c, up_c;
  logic [MANT_BITS-1:0]     sum_c;
`endif

  always_comb begin
    msb_c      = q_q[QBITS-1];
    frac_t_c   = msb_c ? q_q[QBITS-2 -: FRAC_BITS] : q_q[QBITS-3 -: FRAC_BITS];
    exp_t_c    = msb_c ? exp_q : exp_q - SEXP_W'(1);
    frac_c     = frac_t_c;
    exp_c      = exp_t_c;
    norm_res_c = '0;
`ifdef FP_DIV_ROUND_NEAREST_EN
    guard_c  = msb_c ? q_q[2] : q_q[1];
    rnd_c    = msb_c ? q_q[1] : q_q[0];
    sticky_c = (msb_c & q_q[0]) | (|rem_q);
    up_c     = guard_c & (rnd_c | sticky_c | frac_t_c[0]);
    sum_c    = {1'b0, frac_t_c} + MANT_BITS'(up_c);
    frac_c   = sum_c[FRAC_BITS-1:0];
    if (sum_c[MANT_BITS-1]) begin
      exp_c = exp_t_c + SEXP_W'(1);
    end
`endif
    if (exp_c >= SEXP_W'(255)) begin
      norm_res_c = {sign_q, POS_INF[WORD_W-2:0]};
    end else if (exp_c <= SEXP_W'(0)) begin
      norm_res_c = {sign_q, (WORD_W-1)'(0)};
    end else begin
      norm_res_c = {sign_q, exp_c[EXP_W-1:0], frac_c};
    end
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      nan_q      <= 1'b0;
      sign_q     <= 1'b0;
      rem_q      <= '0;
      mb_q       <= '0;
      q_q        <= '0;
      exp_q      <= '0;
      cnt_q      <= '0;
      bus.Result <= '0;
      bus.Ready  <= 1'b0;
      bus.NaN    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.En) begin
            a_q       <= bus.A;
            b_q       <= bus.B;
            bus.Ready <= 1'b0;
            bus.NaN   <= 1'b0;
            state     <= ST_UNPACK;
          end else if ((state == ST_DONE) && !bus.Ready) begin
            bus.Result <= res_q;
            bus.NaN    <= nan_q;
            bus.Ready  <= 1'b1;
          end
        end
        ST_UNPACK: begin
          sign_q <= sa ^ sb;
          exp_q  <= SEXP_W'(ea) - SEXP_W'(eb) + SEXP_W'(BIAS);
          rem_q  <= REM_W'(ma);
          mb_q   <= mb;
          q_q    <= '0;
          cnt_q  <= '0;
          nan_q  <= 1'b0;
          state  <= ST_DONE;
          if (na || nb || (za && zb) || (ia && ib)) begin
            res_q <= QNAN;
            nan_q <= 1'b1;
          end else if (ia || zb) begin
            res_q <= {sa ^ sb, POS_INF[WORD_W-2:0]};
          end else if (ib || za) begin
            res_q <= {sa ^ sb, (WORD_W-1)'(0)};
          end else begin
            state <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          rem_q <= (ge_c ? diff_c : rem_q) << 1;
          q_q   <= {q_q[QBITS-2:0], ge_c};
          if (cnt_q == CNT_W'(QBITS - 1)) begin
            state <= ST_NORM;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_NORM: begin
          res_q <= norm_res_c;
          nan_q <= 1'b0;
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_divider.sv
// Self-checking bench for fp32_divider: directed cases plus random operands vs. an arithmetic model.
module tb_fp32_divider;

  localparam logic [31:0] Q_NAN = 32'h7FC0_0000;
`ifdef FP_DIV_ROUND_NEAREST_EN
  localparam int          LAT_N   = 30;
  localparam logic [31:0] NEG_DIV = 32'hC02A_AAAB;
`else
  localparam int          LAT_N   = 28;
  localparam logic [31:0] NEG_DIV = 32'hC02A_AAAA;
`endif
  localparam int LAT_S = 2;

  logic clk;
  logic rst_n;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total    = 0;

  fp32_divider_if bus ();

  fp32_divider dut (.clk(clk), .reset(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer quotient, then truncate or round-to-nearest-even.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic nan, output int lat);
    int ea, eb, e;
    longint unsigned fa, fb, ma, mb, num, q, rm, mant;
    bit s, az, bz, ai, bi, an, bn;
`ifdef FP_DIV_ROUND_NEAREST_EN
    longint unsigned rest;
`endif
    s   = a[31] ^ b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    fa  = 64'(a[22:0]);
    fb  = 64'(b[22:0]);
    az  = (ea == 0);
    bz  = (eb == 0);
    ai  = (ea == 255) && (fa == 0);
    bi  = (eb == 255) && (fb == 0);
    an  = (ea == 255) && (fa != 0);
    bn  = (eb == 255) && (fb != 0);
    nan = 1'b0;
    lat = LAT_S;
    if (an || bn || (az && bz) || (ai && bi)) begin
      r   = Q_NAN;
      nan = 1'b1;
      return;
    end
    if (ai || bz) begin
      r = {s, 8'hFF, 23'h0};
      return;
    end
    if (bi || az) begin
      r = {s, 31'h0};
      return;
    end
    lat = LAT_N;
    ma  = fa + 64'h80_0000;
    mb  = fb + 64'h80_0000;
    e   = ea - eb + 127;
    if (ma < mb) begin
      e   = e - 1;
      num = ma << 31;
    end else begin
      num = ma << 30;
    end
    q    = num / mb;
    rm   = num % mb;
    mant = q >> 7;
`ifdef FP_DIV_ROUND_NEAREST_EN
    rest = q & 64'd127;
    if (rest > 64'd64 || (rest == 64'd64 && (rm != 0 || mant[0])))
      mant = mant + 1;
    if (mant == 64'h100_0000) begin
      mant = mant >> 1;
      e    = e + 1;
    end
`else
    if (rm == 0 && mant == 0) mant = 0;
`endif
    if (e >= 255)     r = {s, 8'hFF, 23'h0};
    else if (e <= 0)  r = {s, 31'h0};
    else              r = {s, 8'(e), 23'(mant)};
  endfunction

  // One transaction: En held for `hold` edges; optional stray En pulse mid-divide.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input logic exp_nan, input int exp_lat,
                       input int hold, input bit pulse_mid);
    int n;
    @(negedge clk);
    bus.A  = a;
    bus.B  = b;
    bus.En = 1'b1;
    for (int i = 0; i < hold; i++) @(posedge clk);
    #1;
    check({tag, "/ready_drop"}, 32'(bus.Ready), 32'd0);
    bus.En = 1'b0;
    n = hold - 1;
    while (!bus.Ready && n < 80) begin
      @(posedge clk);
      #1;
      n++;
      if (pulse_mid && n == 6) begin
        bus.A  = 32'h3F80_0000;
        bus.B  = 32'h4000_0000;
        bus.En = 1'b1;
      end else begin
        bus.En = 1'b0;
      end
    end
    check({tag, "/latency"}, 32'(n), 32'(exp_lat));
    check({tag, "/result"}, bus.Result, exp_r);
    check({tag, "/nan"}, 32'(bus.NaN), 32'(exp_nan));
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    int sel;
    v   = $urandom;
    sel = $urandom_range(0, 15);
    case (sel)
      0:       v[30:23] = 8'h00;
      1:       begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
      2:       begin v[30:23] = 8'hFF; v[22] = 1'b1; end
      3:       v[30:23] = (v[0]) ? 8'hFE : 8'h01;
      default: v[30:23] = 8'(127 + $urandom_range(0, 60) - 30);
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] a, b, er;
    logic        en_nan;
    int          el;

    rst_n  = 1'b0;
    bus.A  = '0;
    bus.B  = '0;
    bus.En = 1'b0;
    #12;
    check("reset/result", bus.Result, 32'h0);
    check("reset/ready", 32'(bus.Ready), 32'd0);
    check("reset/nan", 32'(bus.NaN), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("2div1",     32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, LAT_N, 1, 1'b0);
    do_op("3.75div1.5",32'h4070_0000, 32'h3FC0_0000, 32'h4020_0000, 1'b0, LAT_N, 1, 1'b0);
    do_op("sign_pn",   32'h4040_0000, 32'hBFC0_0000, 32'hC000_0000, 1'b0, LAT_N, 1, 1'b0);
    do_op("sign_np",   32'hC000_0000, 32'h3F40_0000, NEG_DIV,       1'b0, LAT_N, 1, 1'b0);
    do_op("sign_nn",   32'hBFC0_0000, 32'hC000_0000, 32'h3F40_0000, 1'b0, LAT_N, 1, 1'b0);
    do_op("x_div_0",   32'h40A0_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, LAT_S, 1, 1'b0);
    do_op("0_div_x",   32'h0000_0000, 32'h4040_0000, 32'h0000_0000, 1'b0, LAT_S, 1, 1'b0);
    do_op("inf_div_x", 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b0, LAT_S, 1, 1'b0);
    do_op("x_div_inf", 32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 1'b0, LAT_S, 1, 1'b0);
    do_op("0_div_0",   32'h0000_0000, 32'h0000_0000, Q_NAN,         1'b1, LAT_S, 1, 1'b0);
    do_op("nan_div_x", 32'h7FC0_0000, 32'h4000_0000, Q_NAN,         1'b1, LAT_S, 1, 1'b0);
    do_op("inf_inf",   32'hFF80_0000, 32'h7F80_0000, Q_NAN,         1'b1, LAT_S, 1, 1'b0);
    do_op("overflow",  32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 1'b0, LAT_N, 1, 1'b0);
    do_op("underflow", 32'h0080_0000, 32'h7F7F_FFFF, 32'h0000_0000, 1'b0, LAT_N, 1, 1'b0);
    do_op("neg_inf",   32'hC0A0_0000, 32'h0000_0000, 32'hFF80_0000, 1'b0, LAT_S, 1, 1'b0);
    do_op("en_held2",  32'h4070_0000, 32'h3FC0_0000, 32'h4020_0000, 1'b0, LAT_N, 2, 1'b0);
    do_op("en_mid",    32'hC000_0000, 32'h3F40_0000, NEG_DIV,       1'b0, LAT_N, 1, 1'b1);

    // Abort a divide with reset and confirm no result ever appears.
    @(negedge clk);
    bus.A  = 32'h4000_0000;
    bus.B  = 32'h3F80_0000;
    bus.En = 1'b1;
    @(posedge clk);
    #1 bus.En = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset/result", bus.Result, 32'h0);
    check("midreset/ready", 32'(bus.Ready), 32'd0);
    check("midreset/nan", 32'(bus.NaN), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("midreset/no_ready", 32'(bus.Ready), 32'd0);
    do_op("after_reset", 32'h4040_0000, 32'hBFC0_0000, 32'hC000_0000, 1'b0, LAT_N, 1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      a = rand_operand();
      b = rand_operand();
      ref_div(a, b, er, en_nan, el);
      do_op($sformatf("rnd%0d_%h_%h", k, a, b), a, b, er, en_nan, el, 1, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
